// File: rtl/riscv_definitions.sv
`default_nettype none
// ============================================================================
//  Package     : riscv_definitions
//  Description : Shared RISC-V decode types.  imm_src_t selects the immediate
//                format that the immediate generator extracts from an
//                instruction word.  IMM_Z is the 5-bit CSR zimm (rs1 field).
//                Encodings 6 and 7 are undefined and flagged as illegal.
//  Revision    : 1.1 - IMM_Z format added
// ============================================================================
package riscv_definitions;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_Z = 3'd5
    } imm_src_t;

endpackage : riscv_definitions
`default_nettype wire

// File: rtl/imm_format.sv
`default_nettype none
// ============================================================================
//  Module      : imm_format
//  Description : Purely combinational immediate extraction.  Every format is
//                first assembled as a 32-bit value, then sign-extended to XLEN.
//                IMM_Z is assembled with zero upper bits, so sign extension
//                leaves it zero-extended.
//  Ports       : i_instr   [31:7]  immediate-bearing instruction bits
//                i_imm_src         format select
//                o_imm     [XLEN]  extended immediate (0 when illegal)
//                o_illegal         i_imm_src is not a defined encoding
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_format
    import riscv_definitions::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     i_instr,
    input  imm_src_t        i_imm_src,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);

    logic [31:0] w_imm32;

    always_comb begin
        w_imm32   = 32'd0;
        o_illegal = 1'b0;
        case (i_imm_src)
            IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {i_instr[31:12], 12'd0};
            IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            IMM_Z:   w_imm32 = {27'd0, i_instr[19:15]};
            default: o_illegal = 1'b1;
        endcase
    end

    // Only 32 and 64 are meaningful widths; anything else is treated as 32.
    if (XLEN == 64) begin : g_ext64
        assign o_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_ext32
        assign o_imm = w_imm32[XLEN-1:0];
    end

endmodule : imm_format
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Registered immediate generator with valid/ready handshake and
//                a two-entry in-order buffer (main + skid).  The main entry
//                drives the outputs directly; the skid entry absorbs the one
//                request that can be accepted while the output is stalled.
//                o_ready depends on registered occupancy only.
//  Ports       : i_clk, i_rst (sync, active-high)
//                i_valid/o_ready  request handshake; i_instr, i_imm_src, i_tag
//                o_valid/i_ready  result handshake;  o_imm, o_tag, o_illegal
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
    import riscv_definitions::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:7]      i_instr,
    input  imm_src_t         i_imm_src,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_t;

    occ_t             state_q,       state_d;
    logic [XLEN-1:0]  main_imm_q,    main_imm_d;
    logic [TAG_W-1:0] main_tag_q,    main_tag_d;
    logic             main_ill_q,    main_ill_d;
    logic [XLEN-1:0]  skid_imm_q,    skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q,    skid_tag_d;
    logic             skid_ill_q,    skid_ill_d;

    logic [XLEN-1:0]  w_new_imm;
    logic             w_new_ill;
    logic             w_push;
    logic             w_pop;

    imm_format #(
        .XLEN (XLEN)
    ) u_imm_format (
        .i_instr   (i_instr),
        .i_imm_src (i_imm_src),
        .o_imm     (w_new_imm),
        .o_illegal (w_new_ill)
    );

    assign o_ready   = (state_q != ST_TWO);
    assign o_valid   = (state_q != ST_EMPTY);
    assign o_imm     = main_imm_q;
    assign o_tag     = main_tag_q;
    assign o_illegal = main_ill_q;

    assign w_push = i_valid && o_ready;
    assign w_pop  = o_valid && i_ready;

    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_tag_d = main_tag_q;
        main_ill_d = main_ill_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        skid_ill_d = skid_ill_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_push) begin
                    main_imm_d = w_new_imm;
                    main_tag_d = i_tag;
                    main_ill_d = w_new_ill;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    // Streaming: the new result replaces the one leaving.
                    main_imm_d = w_new_imm;
                    main_tag_d = i_tag;
                    main_ill_d = w_new_ill;
                end else if (w_push) begin
                    // Output stalled: park the new result behind it.
                    skid_imm_d = w_new_imm;
                    skid_tag_d = i_tag;
                    skid_ill_d = w_new_ill;
                    state_d    = ST_TWO;
                end else if (w_pop) begin
                    state_d    = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // No push is possible here because o_ready is low.
                if (w_pop) begin
                    main_imm_d = skid_imm_q;
                    main_tag_d = skid_tag_q;
                    main_ill_d = skid_ill_q;
                    state_d    = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_EMPTY;
            main_imm_q <= '0;
            main_tag_q <= '0;
            main_ill_q <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_imm_q <= main_imm_d;
            main_tag_q <= main_tag_d;
            main_ill_q <= main_ill_d;
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
            skid_ill_q <= skid_ill_d;
        end
    end

endmodule : imm_gen_pipe
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Self-checking bench for imm_gen_pipe (XLEN=32, TAG_W=5).
//                Inputs are driven and outputs sampled 1 time unit after the
//                rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;
    import riscv_definitions::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_valid;
    logic             o_ready;
    logic [31:7]      i_instr;
    imm_src_t         i_imm_src;
    logic [TAG_W-1:0] i_tag;
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_imm;
    logic [TAG_W-1:0] o_tag;
    logic             o_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    imm_gen_pipe #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_instr   (i_instr),
        .i_imm_src (i_imm_src),
        .i_tag     (i_tag),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_imm     (o_imm),
        .o_tag     (o_tag),
        .o_illegal (o_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        imm_src_t    src;
        logic [31:0] exp_imm;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input imm_src_t src,
                         input logic [TAG_W-1:0] tag);
        i_valid   = v;
        i_instr   = instr[31:7];
        i_imm_src = src;
        i_tag     = tag;
    endtask

    logic [31:0] held_imm;

    initial begin
        vecs[0]  = '{32'hFFF00093, IMM_I, 32'hFFFFFFFF, 1'b0};
        vecs[1]  = '{32'h7FF00013, IMM_I, 32'h000007FF, 1'b0};
        vecs[2]  = '{32'h123450B7, IMM_U, 32'h12345000, 1'b0};
        vecs[3]  = '{32'h800002B7, IMM_U, 32'h80000000, 1'b0};
        vecs[4]  = '{32'hFE000EE3, IMM_B, 32'hFFFFFFFC, 1'b0};
        vecs[5]  = '{32'hFE000C23, IMM_S, 32'hFFFFFFF8, 1'b0};
        vecs[6]  = '{32'h7E000FA3, IMM_S, 32'h000007FF, 1'b0};
        vecs[7]  = '{32'hFFDFF06F, IMM_J, 32'hFFFFFFFC, 1'b0};
        vecs[8]  = '{32'h0080006F, IMM_J, 32'h00000008, 1'b0};
        vecs[9]  = '{32'h000F8073, IMM_Z, 32'h0000001F, 1'b0};
        vecs[10] = '{32'h00028073, IMM_Z, 32'h00000005, 1'b0};
        vecs[11] = '{32'hFFFFFFFF, imm_src_t'(3'd6), 32'h00000000, 1'b1};
        vecs[12] = '{32'hFFFFFFFF, imm_src_t'(3'd7), 32'h00000000, 1'b1};

        rst = 1'b1;
        i_ready = 1'b1;
        drive(1'b0, 32'h0, IMM_I, '0);
        step();
        step();
        check("reset o_valid",   o_valid,   0);
        check("reset o_ready",   o_ready,   1);
        check("reset o_imm",     o_imm,     0);
        check("reset o_tag",     o_tag,     0);
        check("reset o_illegal", o_illegal, 0);
        rst = 1'b0;

        // Back-to-back table: each result appears the cycle after its push,
        // while the previous one is popped in the same cycle.
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].src, TAG_W'(i));
            check("tbl o_ready", o_ready, 1);
            step();
            check($sformatf("tbl[%0d] o_valid", i),   o_valid,   1);
            check($sformatf("tbl[%0d] o_imm", i),     o_imm,     vecs[i].exp_imm);
            check($sformatf("tbl[%0d] o_tag", i),     o_tag,     i);
            check($sformatf("tbl[%0d] o_illegal", i), o_illegal, vecs[i].exp_ill);
        end
        drive(1'b0, 32'h0, IMM_I, '0);
        step();
        check("drain o_valid", o_valid, 0);

        // Backpressure: tags 1,2 fill the buffer, tag 3 must be refused.
        i_ready = 1'b0;
        drive(1'b1, 32'h00100013, IMM_I, 5'd1);
        step();
        drive(1'b1, 32'h00200013, IMM_I, 5'd2);
        check("bp o_ready one", o_ready, 1);
        step();
        drive(1'b1, 32'h00300013, IMM_I, 5'd3);
        check("bp o_ready two", o_ready, 0);
        check("bp head tag",    o_tag,   1);
        held_imm = o_imm;
        check("bp head imm",    o_imm,   32'h1);
        step();
        check("bp stall tag",   o_tag,   1);
        check("bp stall imm",   o_imm,   held_imm);
        check("bp stall valid", o_valid, 1);
        drive(1'b0, 32'h0, IMM_I, '0);
        i_ready = 1'b1;
        step();
        check("bp second tag",   o_tag,   2);
        check("bp second imm",   o_imm,   32'h2);
        check("bp second valid", o_valid, 1);
        step();
        check("bp tag3 dropped", o_valid, 0);

        // Streaming in ONE for 10 cycles.
        drive(1'b1, 32'h00A00013, IMM_I, 5'd10);
        step();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'(11 + k) << 20, IMM_I, TAG_W'(11 + k));
            check("pp o_ready", o_ready, 1);
            check("pp o_valid", o_valid, 1);
            check($sformatf("pp[%0d] tag", k), o_tag, 10 + k);
            check($sformatf("pp[%0d] imm", k), o_imm, 10 + k);
            step();
        end
        drive(1'b0, 32'h0, IMM_I, '0);
        check("pp last tag", o_tag, 20);
        step();
        check("pp drain", o_valid, 0);

        // Reset while holding two results plus a same-cycle request.
        i_ready = 1'b0;
        drive(1'b1, 32'h00400013, IMM_I, 5'd4);
        step();
        drive(1'b1, 32'h00500013, IMM_I, 5'd5);
        step();
        check("rst pre o_ready", o_ready, 0);
        rst = 1'b1;
        drive(1'b1, 32'h00600013, IMM_I, 5'd6);
        step();
        check("rst o_valid",   o_valid,   0);
        check("rst o_ready",   o_ready,   1);
        check("rst o_imm",     o_imm,     0);
        check("rst o_tag",     o_tag,     0);
        rst = 1'b0;
        i_ready = 1'b1;
        drive(1'b1, 32'h00900013, IMM_I, 5'd9);
        step();
        check("post rst valid", o_valid, 1);
        check("post rst tag",   o_tag,   9);
        check("post rst imm",   o_imm,   32'h9);
        drive(1'b0, 32'h0, IMM_I, '0);
        step();
        check("post rst drain", o_valid, 0);
        step();
        check("post rst idle", o_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_imm_gen_pipe
`default_nettype wire

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 SHALL have parameter TAG_W, default 5, width of the sideband tag carried alongside each immediate.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_valid  input  1  upstream request valid.
REQ-006 SHALL have port o_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port i_instr  input  [31:7]  instruction immediate-bearing bits.
REQ-008 SHALL have port i_imm_src  input  imm_src_t  immediate format select.
REQ-009 SHALL have port i_tag  input  TAG_W  opaque sideband, returned unchanged.
REQ-010 SHALL have port o_valid  output  1  result valid.
REQ-011 SHALL have port i_ready  input  1  downstream accepts result.
REQ-012 SHALL have port o_imm  output  XLEN  extended immediate.
REQ-013 SHALL have port o_tag  output  TAG_W  tag of the presented result.
REQ-014 SHALL have port o_illegal  output  1  presented request had an undefined i_imm_src.

Function
REQ-015 SHALL accept a request when i_valid && o_ready and pop a result when o_valid && i_ready.
REQ-016 SHALL present an accepted request on o_* no earlier than the cycle after acceptance (latency 1, registered outputs).
REQ-017 SHALL buffer up to 2 results in order (main + skid entry); occupancy states EMPTY, ONE, TWO.
REQ-018 SHALL transition: EMPTY+push->ONE; ONE+push only->TWO; ONE+pop only->EMPTY; ONE+push+pop->ONE; TWO+pop->ONE; all other cases hold.
REQ-019 SHALL drive o_ready = 1 in EMPTY/ONE and 0 in TWO, from registered state only (no combinational path from i_ready).
REQ-020 SHALL hold o_imm, o_tag, o_illegal stable while o_valid && !i_ready.
REQ-021 SHALL compute IMM_I as i_instr[31:20], sign-extended from bit 31 to XLEN.
REQ-022 SHALL compute IMM_S as {i_instr[31:25], i_instr[11:7]}, sign-extended.
REQ-023 SHALL compute IMM_B as {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 0}, sign-extended.
REQ-024 SHALL compute IMM_U as {i_instr[31:12], 12'b0}, sign-extended to XLEN.
REQ-025 SHALL compute IMM_J as {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 0}, sign-extended.
REQ-026 SHALL compute IMM_Z (CSR zimm) as i_instr[19:15] zero-extended to XLEN.
REQ-027 SHALL, for any other i_imm_src encoding, produce o_imm = 0 and o_illegal = 1; o_illegal = 0 otherwise.
REQ-028 SHALL ignore i_instr, i_imm_src, i_tag in cycles without acceptance.

Reset
REQ-029 SHALL, on i_rst high at a clock edge, go to EMPTY: o_valid=0, o_ready=1, o_imm=0, o_tag=0, o_illegal=0.
REQ-030 SHALL discard any buffered or same-cycle-accepted request when reset asserts mid-operation; no result appears after reset.
REQ-031 SHALL accept a new request in the first cycle after i_rst deasserts.

Structure
REQ-032 SHALL extend imm_src_t in riscv_definitions with IMM_Z; no new package.
REQ-033 SHALL place format extraction in one combinational sub-module imm_format (XLEN-parameterised); buffering and handshake stay in imm_gen_pipe.

Verification
REQ-034 SHALL check I-type: i_instr from 0xFFF00093, IMM_I, i_ready=1 -> next cycle o_valid=1, o_imm=0xFFFFFFFF (XLEN=64: 0xFFFFFFFFFFFFFFFF).
REQ-035 SHALL check U/B: LUI 0x123450B7 -> o_imm=0x12345000; BEQ 0xFE000EE3 with IMM_B -> o_imm=0xFFFFFFFC.
REQ-036 SHALL check backpressure: i_ready=0, push tags 1,2,3 on consecutive cycles -> o_ready low after two pushes, tag 3 not accepted; release i_ready -> tags 1,2 emerge in order, output stable while stalled.
REQ-037 SHALL check simultaneous push+pop in ONE for 10 cycles -> one result per cycle, occupancy stays ONE, no loss or reorder.
REQ-038 SHALL check IMM_Z: rs1 field 31 -> o_imm=0x1F; undefined i_imm_src -> o_imm=0, o_illegal=1.
REQ-039 SHALL check reset with TWO occupancy -> next cycle o_valid=0, o_ready=1, buffered tags never appear.
